arb2_sel: RTL and testbench
===========================

ARB2_SEL -- requirements
Module: arb2_sel

Interface
REQ-001 Parameter: DW, 8, data width of each input and the output.
REQ-002 Parameter: CW, 8, width of each grant counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in0_data  input  DW  source 0 payload.
REQ-006 Port: in0_valid  input  1  source 0 payload valid.
REQ-007 Port: in0_ready  output  1  source 0 transfer accepted this cycle.
REQ-008 Port: in1_data  input  DW  source 1 payload.
REQ-009 Port: in1_valid  input  1  source 1 payload valid.
REQ-010 Port: in1_ready  output  1  source 1 transfer accepted this cycle.
REQ-011 Port: out_data  output  DW  registered winning payload.
REQ-012 Port: out_valid  output  1  out_data holds a pending word.
REQ-013 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-014 Port: sel  output  1  registered source index of out_data; drives the select of the downstream 2:1 mux.
REQ-015 Port: cnt_clr  input  1  synchronous clear of both grant counters.
REQ-016 Port: cnt0, cnt1  output  CW each  accepted-transfer counts per source.

Function
REQ-017 A transfer on input i SHALL occur exactly when ini_valid and ini_ready are both 1 at a rising edge; same for output with out_valid/out_ready.
REQ-018 FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1); out_valid SHALL equal (state==FULL).
REQ-019 load = (state==EMPTY) or out_ready; arbitration SHALL take place only when load=1.
REQ-020 Grant when load=1: only in0_valid -> 0; only in1_valid -> 1; both -> NOT last; neither -> no grant.
REQ-021 ini_ready SHALL be 1 only for the granted source, combinationally from valid, state and out_ready; never both 1 in one cycle.
REQ-022 On grant: out_data <= granted data, sel <= granted index, last <= granted index, state <= FULL; latency input accept to out_valid = 1 cycle.
REQ-023 EMPTY with no grant: stay EMPTY. FULL with out_ready=1 and no grant: -> EMPTY. FULL with out_ready=0: hold out_data, sel, last unchanged (no grant).
REQ-024 FULL with out_ready=1 and a grant: drain and reload same edge, stay FULL; zero-bubble throughput of 1 word/cycle.
REQ-025 Under continuous both-valid and out_ready=1, sel SHALL alternate 0,1,0,1,... starting from 0 after reset.
REQ-026 cnti SHALL increment by 1 on each source-i transfer, saturating at 2^CW-1 (no wrap).
REQ-027 cnt_clr=1 SHALL force both counters to 0 that edge, overriding a simultaneous increment.
REQ-028 Input payloads SHALL never be sampled when not granted; out_data SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-029 rst=1 at an edge SHALL force: state EMPTY, out_valid 0, out_data 0, sel 0, last 1, cnt0 0, cnt1 0; in0_ready=in1_ready=0 while rst=1.
REQ-030 rst mid-transfer SHALL discard the pending output word; no transfer is counted on the reset edge.

Structure
REQ-031 State encodings (EMPTY=0, FULL=1) and source indices SHALL live in a shared package arb2_pkg.
REQ-032 Saturating counter SHALL be one sub-module sat_cnt (params CW; ports clk, rst, clr, inc, q), instantiated twice.

Verification
REQ-033 Reset: rst=1 two cycles with both valid -> out_valid=0, sel=0, readies 0, counters 0.
REQ-034 Both valid, out_ready=1 held, in0_data=0xA0.., in1_data=0xB0.. -> out_data A0,B0,A1,B1..., sel 0,1,0,1, no bubbles.
REQ-035 Backpressure: FULL with out_ready=0 for 5 cycles -> out_data/sel stable, in0_ready=in1_ready=0; release -> next word follows immediately.
REQ-036 Only in1_valid for 3 cycles -> three words with sel=1, cnt1=3, cnt0=0; then both valid -> source 0 wins.
REQ-037 CW=2, 5 source-0 transfers -> cnt0 saturates at 3; cnt_clr with simultaneous transfer -> cnt0=0.
REQ-038 rst asserted while FULL and out_ready=0 -> next cycle out_valid=0, pending word never appears on output.

Source files
------------

// File: rtl/arb2_pkg.sv
// Shared encodings for the two-source arbiter: FSM states and source indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb2_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; counts accepted transfers.
// Latency: q reflects an increment one cycle after inc is sampled.
// Backpressure: none; clr wins over a simultaneous inc, holds at all-ones.
module sat_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear dominates, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/arb2_sel.sv
// Two-source round-robin arbiter into a one-word output register with source select.
// Latency: one cycle from input accept to out_valid.
// Backpressure: output held while out_ready=0; readies drop, reload same edge on drain.
module arb2_sel
    import arb2_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_valid,
    output logic          in1_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sel,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    state_e        state_q, state_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;

    logic          load;
    logic          gnt_vld;
    logic          gnt_idx;

    // Arbitration: only when the output register is free or draining this edge.
    // Readies are forced low during reset so nothing is accepted or counted.
    always_comb begin
        load    = (state_q == ST_EMPTY) || out_ready;
        gnt_vld = 1'b0;
        gnt_idx = SRC0;
        if (!rst && load) begin
            if (in0_valid && in1_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = ~last_q;
            end else if (in0_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC0;
            end else if (in1_valid) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC1;
            end
        end
        in0_ready = gnt_vld && (gnt_idx == SRC0);
        in1_ready = gnt_vld && (gnt_idx == SRC1);
    end

    // Next state: load the granted word, drain to EMPTY, or hold under backpressure.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (gnt_vld) begin
            dat_d   = (gnt_idx == SRC1) ? in1_data : in0_data;
            sel_d   = gnt_idx;
            last_d  = gnt_idx;
            state_d = ST_FULL;
        end else if (load) begin
            state_d = ST_EMPTY;
        end
    end

    // Output register and FSM state; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            dat_q   <= '0;
            sel_q   <= SRC0;
            last_q  <= SRC1;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = dat_q;
    assign sel       = sel_q;

    sat_cnt #(.CW(CW)) u_cnt0 (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (in0_ready),
        .q   (cnt0)
    );

    sat_cnt #(.CW(CW)) u_cnt1 (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (in1_ready),
        .q   (cnt1)
    );

endmodule

// File: tb/tb_arb2_sel.sv
// Self-checking bench for arb2_sel with a reference model and scoreboard queue.
// Latency: model expects accepted words on the output one cycle later.
// Backpressure: exercised by directed out_ready=0 windows and random phases.
module tb_arb2_sel;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in0_data, in1_data;
    logic          in0_valid, in1_valid;
    logic          in0_ready, in1_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          sel;
    logic          cnt_clr;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    arb2_sel #(.DW(DW), .CW(CW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state (what the DUT registers should hold after the last edge).
    logic          m_full = 1'b0;
    logic          m_last = 1'b1;
    logic [DW-1:0] m_dat  = '0;
    logic          m_sel  = 1'b0;
    logic [CW-1:0] m_cnt0 = '0;
    logic [CW-1:0] m_cnt1 = '0;
    logic [DW:0]   sb_q[$];   // {sel, data} of accepted words awaiting output

    // Monitor: sample away from the active edge, compare, then advance the model.
    always @(negedge clk) begin
        logic          g_vld;
        logic          g_idx;
        logic [DW:0]   exp_w;
        g_vld = 1'b0;
        g_idx = 1'b0;
        if (!rst && (!m_full || out_ready)) begin
            if (in0_valid && in1_valid) begin
                g_vld = 1'b1;
                g_idx = ~m_last;
            end else if (in0_valid) begin
                g_vld = 1'b1;
            end else if (in1_valid) begin
                g_vld = 1'b1;
                g_idx = 1'b1;
            end
        end

        chk("out_valid", out_valid, m_full);
        chk("out_data",  out_data,  m_dat);
        chk("sel",       sel,       m_sel);
        chk("in0_ready", in0_ready, g_vld && !g_idx);
        chk("in1_ready", in1_ready, g_vld && g_idx);
        chk("cnt0",      cnt0,      m_cnt0);
        chk("cnt1",      cnt1,      m_cnt1);

        if (rst) begin
            sb_q.delete();
            m_full = 1'b0;
            m_last = 1'b1;
            m_dat  = '0;
            m_sel  = 1'b0;
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            if (m_full && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("pop_data", out_data, exp_w[DW-1:0]);
                    chk("pop_sel",  sel,      exp_w[DW]);
                end
                m_full = 1'b0;
            end
            if (g_vld) begin
                m_dat  = g_idx ? in1_data : in0_data;
                m_sel  = g_idx;
                m_last = g_idx;
                m_full = 1'b1;
                sb_q.push_back({g_idx, m_dat});
            end
            if (cnt_clr) begin
                m_cnt0 = '0;
                m_cnt1 = '0;
            end else if (g_vld) begin
                if (!g_idx && m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
                if (g_idx  && m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
            end
        end
    end

    // One cycle of stimulus: advance each source's payload only after it was accepted.
    task automatic step();
        logic x0, x1;
        @(negedge clk);
        x0 = in0_valid && in0_ready;
        x1 = in1_valid && in1_ready;
        @(posedge clk);
        #1;
        if (x0) in0_data = in0_data + 1'b1;
        if (x1) in1_data = in1_data + 1'b1;
    endtask

    task automatic drive(input logic v0, input logic v1, input logic ordy, input int n);
        in0_valid = v0;
        in1_valid = v1;
        out_ready = ordy;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b1;
        cnt_clr   = 1'b0;
        in0_data  = 8'hA0;
        in1_data  = 8'hB0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles with both sources valid.
        for (int i = 0; i < 2; i++) step();
        rst = 1'b0;

        // Alternating stream A0,B0,A1,B1... with no bubbles.
        drive(1, 1, 1, 8);

        // Backpressure: hold five cycles, then release.
        drive(1, 1, 0, 5);
        drive(1, 1, 1, 2);

        // Clear counters, then only source 1 for three transfers, then both.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(0, 1, 1, 3);
        drive(1, 1, 1, 2);

        // Source 0 only: five transfers saturate the 2-bit counter.
        drive(0, 0, 1, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(1, 0, 1, 5);
        // Clear while a transfer is accepted.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(1, 0, 1, 1);

        // Reset while FULL and stalled: the pending word must vanish.
        drive(1, 1, 0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 300; i++) begin
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            step();
        end
        cnt_clr = 1'b0;
        drive(0, 0, 1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
